// File: rtl/drum_pkg.sv
// Shared types and constants for the drum trigger sequencer: ADSR preset table,
// FSM state encoding and the bit layout of a pattern entry.
package drum_pkg;

  typedef struct packed {
    logic [7:0] attack_step_value;
    logic [7:0] decay_step_value;
    logic [7:0] sustain_level;
    logic [7:0] release_step_value;
    logic [7:0] sustain_time;
  } adsr_preset_t;

  // kick, snare, hat, tom
  localparam adsr_preset_t PRESETS [4] = '{
    '{8'h08, 8'h04, 8'h40, 8'h02, 8'h20},
    '{8'h10, 8'h08, 8'h30, 8'h04, 8'h10},
    '{8'h20, 8'h10, 8'h10, 8'h08, 8'h04},
    '{8'h08, 8'h04, 8'h60, 8'h02, 8'h30}
  };

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_COUNT} seq_state_t;

  localparam int PAT_W          = 4;
  localparam int PAT_HIT        = 0;
  localparam int PAT_PRESET_LSB = 1;
  localparam int PAT_PRESET_MSB = 2;
  localparam int PAT_ACCENT     = 3;

endpackage

// File: rtl/drum_pattern_ram.sv
// STEPS x 4 pattern store. Asynchronous read of the old contents makes a write
// to the address being read in the same cycle visible only on the next access.
module drum_pattern_ram
  import drum_pkg::*;
#(
  parameter int STEPS = 16,
  localparam int AW = $clog2(STEPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PAT_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [PAT_W-1:0] rdata
);

  logic [PAT_W-1:0] mem [STEPS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STEPS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/drum_trigger_sequencer.sv
// Pattern step sequencer driving the volume_shaper trigger interface.
// Define ACCENT_EN to let pattern bit 3 force sustain_level to full scale.
module drum_trigger_sequencer
  import drum_pkg::*;
#(
  parameter int STEPS  = 16,
  parameter int TICK_W = 24,
  localparam int AW = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [TICK_W-1:0] tempo_div,
  input  logic              pat_we,
  input  logic [AW-1:0]     pat_addr,
  input  logic [PAT_W-1:0]  pat_data,
  input  logic              adsr_idle,
  output logic              start,
  output logic [7:0]        attack_step_value,
  output logic [7:0]        decay_step_value,
  output logic [7:0]        sustain_level,
  output logic [7:0]        release_step_value,
  output logic [7:0]        sustain_time,
  output logic [AW-1:0]     step_idx,
  output logic [7:0]        drop_count
);

  seq_state_t        state;
  logic [TICK_W-1:0] tick;
  logic [TICK_W-1:0] div_l;
  logic [PAT_W-1:0]  pat_rd;
  adsr_preset_t      params;
  adsr_preset_t      sel;

  drum_pattern_ram #(.STEPS(STEPS)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (pat_we),
    .waddr (pat_addr),
    .wdata (pat_data),
    .raddr (step_idx),
    .rdata (pat_rd)
  );

  always_comb begin
    sel = PRESETS[pat_rd[PAT_PRESET_MSB:PAT_PRESET_LSB]];
`ifdef ACCENT_EN
    if (pat_rd[PAT_ACCENT]) sel.sustain_level = 8'hFF;
`endif
  end

`ifndef ACCENT_EN
  logic unused_accent;
  assign unused_accent = pat_rd[PAT_ACCENT];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      start      <= 1'b0;
      step_idx   <= '0;
      drop_count <= '0;
      tick       <= '0;
      div_l      <= TICK_W'(1);
      params     <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state    <= S_FIRE;
            step_idx <= '0;
            tick     <= '0;
          end
        end
        S_FIRE: begin
          if (!run) begin
            state    <= S_IDLE;
            step_idx <= '0;
            tick     <= '0;
          end else begin
            // tempo_div=0 would give a zero-length count; clamp to one
            div_l <= (tempo_div == '0) ? TICK_W'(1) : tempo_div;
            if (pat_rd[PAT_HIT]) begin
              if (adsr_idle) begin
                start  <= 1'b1;
                params <= sel;
              end else if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
              end
            end
            tick  <= '0;
            state <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (!run) begin
            state    <= S_IDLE;
            step_idx <= '0;
            tick     <= '0;
          end else if (tick == div_l - TICK_W'(1)) begin
            step_idx <= step_idx + AW'(1);
            tick     <= '0;
            state    <= S_FIRE;
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign attack_step_value  = params.attack_step_value;
  assign decay_step_value   = params.decay_step_value;
  assign sustain_level      = params.sustain_level;
  assign release_step_value = params.release_step_value;
  assign sustain_time       = params.sustain_time;

endmodule

// File: tb/tb_drum_trigger_sequencer.sv
// Self-checking bench for drum_trigger_sequencer (STEPS=16); honours ACCENT_EN if defined.
module tb_drum_trigger_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, pat_we, adsr_idle, start;
  logic [23:0] tempo_div;
  logic [3:0]  pat_addr, pat_data, step_idx;
  logic [7:0]  atk, dec, sus, rel, stime, drop_count;
  logic [39:0] params;
  logic [3:0]  pat_m [16];
  int          tests = 0;
  int          fails = 0;

  drum_trigger_sequencer #(.STEPS(16), .TICK_W(24)) dut (
    .clk(clk), .reset(reset), .run(run), .tempo_div(tempo_div),
    .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data),
    .adsr_idle(adsr_idle), .start(start),
    .attack_step_value(atk), .decay_step_value(dec), .sustain_level(sus),
    .release_step_value(rel), .sustain_time(stime),
    .step_idx(step_idx), .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  assign params = {atk, dec, sus, rel, stime};

  function automatic logic [39:0] preset_of(input logic [3:0] pd);
    logic [39:0] p;
    case (pd[2:1])
      2'd0:    p = 40'h08_04_40_02_20;
      2'd1:    p = 40'h10_08_30_04_10;
      2'd2:    p = 40'h20_10_10_08_04;
      default: p = 40'h08_04_60_02_30;
    endcase
`ifdef ACCENT_EN
    if (pd[3]) p[23:16] = 8'hFF;
`endif
    return p;
  endfunction

  task automatic clk1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; run = 1'b0; pat_we = 1'b0;
    clk1; clk1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) pat_m[i] = 4'h0;
  endtask

  task automatic wr(input int a, input logic [3:0] dt);
    pat_we = 1'b1; pat_addr = 4'(a); pat_data = dt;
    clk1;
    pat_we = 1'b0;
    pat_m[a] = dt;
  endtask

  task automatic test_reset;
    int bad;
    do_reset;
    tests++; if (start !== 1'b0) begin fails++; $display("FAIL reset_start got %b want 0", start); end
    tests++; if (params !== 40'h0) begin fails++; $display("FAIL reset_params got %h want 0", params); end
    tests++; if (step_idx !== 4'd0) begin fails++; $display("FAIL reset_step got %0d want 0", step_idx); end
    tests++; if (drop_count !== 8'd0) begin fails++; $display("FAIL reset_drop got %0d want 0", drop_count); end
    tempo_div = 24'd4; adsr_idle = 1'b1;
    wr(0, 4'b0111);
    bad = 0;
    repeat (20) begin clk1; if (start !== 1'b0) bad++; end
    tests++; if (bad != 0) begin fails++; $display("FAIL idle_no_start got %0d pulses want 0", bad); end
    run = 1'b1;
    for (int e = 1; e <= 6; e++) clk1;
    tests++; if (params !== 40'h08_04_60_02_30) begin fails++; $display("FAIL pre_reset_params got %h want 080460 0230", params); end
    adsr_idle = 1'b0;
    for (int e = 7; e <= 86; e++) clk1;
    tests++; if (drop_count !== 8'd1) begin fails++; $display("FAIL pre_reset_drop got %0d want 1", drop_count); end
    adsr_idle = 1'b1;
    reset = 1'b1;
    clk1;
    tests++; if ({start, params, step_idx, drop_count} !== 53'h0) begin
      fails++; $display("FAIL midrun_reset got start=%b params=%h step=%0d drop=%0d want all 0", start, params, step_idx, drop_count);
    end
    clk1;
    reset = 1'b0; run = 1'b0;
    for (int i = 0; i < 16; i++) pat_m[i] = 4'h0;
    bad = 0;
    repeat (10) begin clk1; if (start !== 1'b0) bad++; end
    run = 1'b1;
    repeat (30) begin clk1; if (start !== 1'b0) bad++; end
    tests++; if (bad != 0) begin fails++; $display("FAIL ram_cleared got %0d pulses want 0", bad); end
    run = 1'b0;
  endtask

  task automatic test_basic;
    logic exp;
    do_reset;
    tempo_div = 24'd4; adsr_idle = 1'b1;
    wr(0, 4'b0001); wr(4, 4'b0001);
    run = 1'b1;
    clk1;
    for (int c = 2; c <= 30; c++) begin
      clk1;
      exp = (c == 2 || c == 22);
      tests++; if (start !== exp) begin fails++; $display("FAIL basic_start c=%0d got %b want %b", c, start, exp); end
      if (exp) begin
        tests++; if (params !== 40'h08_04_40_02_20) begin fails++; $display("FAIL basic_params c=%0d got %h want 0804400220", c, params); end
      end
    end
    run = 1'b0;
  endtask

  task automatic test_drop_saturate;
    int bad;
    do_reset;
    tempo_div = 24'd4; adsr_idle = 1'b0;
    wr(1, 4'b0001);
    run = 1'b1;
    bad = 0;
    for (int e = 1; e <= 24001; e++) begin
      clk1;
      if (start !== 1'b0) bad++;
      if (e == 81) begin
        tests++; if (drop_count !== 8'd1) begin fails++; $display("FAIL drop_one got %0d want 1", drop_count); end
      end
    end
    tests++; if (drop_count !== 8'd255) begin fails++; $display("FAIL drop_saturate got %0d want 255", drop_count); end
    tests++; if (bad != 0) begin fails++; $display("FAIL drop_no_start got %0d pulses want 0", bad); end
    run = 1'b0; adsr_idle = 1'b1;
  endtask

  task automatic test_wrap;
    int pulses;
    logic exp;
    do_reset;
    tempo_div = 24'd4; adsr_idle = 1'b1;
    for (int i = 0; i < 16; i++) wr(i, 4'b0101);
    run = 1'b1;
    pulses = 0;
    for (int e = 1; e <= 83; e++) begin
      clk1;
      exp = (e >= 2) && ((e - 2) % 5 == 0);
      tests++; if (start !== exp) begin fails++; $display("FAIL wrap_start e=%0d got %b want %b", e, start, exp); end
      if (exp) begin
        tests++; if (step_idx !== 4'(pulses % 16) || params !== 40'h20_10_10_08_04) begin
          fails++; $display("FAIL wrap_pulse n=%0d got step=%0d params=%h want step=%0d params=2010100804", pulses, step_idx, params, pulses % 16);
        end
        pulses++;
      end
    end
    tests++; if (pulses != 17) begin fails++; $display("FAIL wrap_count got %0d want 17", pulses); end
    run = 1'b0;
  endtask

  task automatic test_run_drop;
    int bad;
    do_reset;
    tempo_div = 24'd4; adsr_idle = 1'b1;
    for (int i = 0; i < 16; i++) wr(i, 4'b0001);
    run = 1'b1;
    for (int e = 1; e <= 17; e++) clk1;
    tests++; if (start !== 1'b1 || step_idx !== 4'd3) begin fails++; $display("FAIL rundrop_step3 got start=%b step=%0d want 1/3", start, step_idx); end
    clk1;
    run = 1'b0;
    clk1;
    tests++; if (step_idx !== 4'd0 || start !== 1'b0) begin fails++; $display("FAIL rundrop_stop got step=%0d start=%b want 0/0", step_idx, start); end
    bad = 0;
    repeat (20) begin clk1; if (start !== 1'b0 || step_idx !== 4'd0) bad++; end
    tests++; if (bad != 0) begin fails++; $display("FAIL rundrop_idle got %0d bad cycles want 0", bad); end
    run = 1'b1;
    clk1; clk1;
    tests++; if (start !== 1'b1 || step_idx !== 4'd0 || params !== 40'h08_04_40_02_20) begin
      fails++; $display("FAIL rundrop_restart got start=%b step=%0d params=%h want 1/0/0804400220", start, step_idx, params);
    end
    run = 1'b0;
  endtask

  task automatic test_accent;
    logic [39:0] exp;
`ifdef ACCENT_EN
    exp = 40'h10_08_FF_04_10;
`else
    exp = 40'h10_08_30_04_10;
`endif
    do_reset;
    tempo_div = 24'd4; adsr_idle = 1'b1;
    wr(0, 4'b1011);
    run = 1'b1;
    clk1; clk1;
    tests++; if (start !== 1'b1 || params !== exp) begin fails++; $display("FAIL accent got start=%b params=%h want 1/%h", start, params, exp); end
    run = 1'b0;
  endtask

  task automatic test_random;
    int p, dv, n, drops, ne;
    logic cur_idle, exp_start;
    logic [39:0] exp_par;
    for (int trial = 0; trial < 4; trial++) begin
      do_reset;
      tempo_div = 24'($urandom_range(0, 6));
      dv = (tempo_div == 0) ? 1 : int'(tempo_div);
      p = dv + 1;
      for (int i = 0; i < 16; i++) wr(i, 4'($urandom));
      drops = 0; exp_par = 40'h0;
      ne = 2 + 40 * p;
      run = 1'b1;
      for (int e = 1; e <= ne; e++) begin
        cur_idle = ($urandom_range(0, 3) != 0);
        adsr_idle = cur_idle;
        clk1;
        exp_start = 1'b0;
        if (e >= 2 && (e - 2) % p == 0) begin
          n = (e - 2) / p;
          if (pat_m[n % 16][0]) begin
            if (cur_idle) begin exp_start = 1'b1; exp_par = preset_of(pat_m[n % 16]); end
            else if (drops < 255) drops++;
          end
        end
        tests++; if (start !== exp_start || params !== exp_par || drop_count !== 8'(drops) || step_idx !== 4'(((e - 1) / p) % 16)) begin
          fails++;
          $display("FAIL random t=%0d e=%0d got start=%b params=%h drop=%0d step=%0d want %b/%h/%0d/%0d",
                   trial, e, start, params, drop_count, step_idx, exp_start, exp_par, drops, ((e - 1) / p) % 16);
        end
      end
      run = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; pat_we = 1'b0; pat_addr = 4'h0; pat_data = 4'h0;
    adsr_idle = 1'b1; tempo_div = 24'd4;
    test_reset;
    test_basic;
    test_drop_saturate;
    test_wrap;
    test_run_drop;
    test_accent;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
